// File: rtl/spi_reg_peripheral_pkg.sv
// Shared types and helpers for the SPI register peripheral.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_len(int addr_w, int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an external controller and the register peripheral.
interface spi_reg_if;
  logic sclk_i;
  logic copi_i;
  logic ncs_i;
  logic cipo_o;
  logic cipo_oe_o;

  modport slave (
    input  sclk_i,
    input  copi_i,
    input  ncs_i,
    output cipo_o,
    output cipo_oe_o
  );

  modport master (
    output sclk_i,
    output copi_i,
    output ncs_i,
    input  cipo_o,
    input  cipo_oe_o
  );
endinterface

// File: rtl/spi_reg_peripheral_sync_edge_det.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Clearing to 0 means a pin already low at reset release shows no fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 peripheral with a read/write bank of control registers.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_if.slave                   spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_stb_o,
  output logic [ADDR_W-1:0]          wr_addr_o
);

  localparam int FRAME = frame_len(ADDR_W, DATA_W);
  localparam int CMD_W = 1 + ADDR_W;
  localparam int CNT_W = $clog2(FRAME + 2);

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME + 1);
  localparam logic [CNT_W-1:0] CNT_LCMD  = CNT_W'(CMD_W - 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic copi_q, copi_rise, copi_fall;
  logic ncs_q, ncs_rise, ncs_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk, .rst_n, .d_i(spi.sclk_i),
    .q_o(sclk_q), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_copi (
    .clk, .rst_n, .d_i(spi.copi_i),
    .q_o(copi_q), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
    .clk, .rst_n, .d_i(spi.ncs_i),
    .q_o(ncs_q), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{sclk_q, ncs_q, copi_rise, copi_fall};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CMD_W-1:0]    cmd_q, cmd_nx;
  logic [DATA_W-1:0]   data_q, shadow_q, rd_val;
  logic                cipo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q, hit, last_cmd, commit, rd_data;

  assign cmd_nx   = {cmd_q[ADDR_W-1:0], copi_q};
  assign addr_q   = cmd_q[ADDR_W-1:0];
  assign rw_q     = cmd_q[ADDR_W];
  assign last_cmd = (state_q == CMD) && sclk_rise && (cnt_q == CNT_LCMD);
  assign rd_data  = (state_q == DATA) && (rw_q != RW_WRITE);

  always_comb begin
    rd_val = '0;
    hit    = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_nx[ADDR_W-1:0] == ADDR_W'(k))
        rd_val = regs_o[k*DATA_W +: DATA_W];
      if (addr_q == ADDR_W'(k))
        hit = 1'b1;
    end
  end

  assign commit = (state_q == DATA) && ncs_rise && (rw_q == RW_WRITE)
               && (cnt_q == CNT_FRAME) && hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ncs_fall) state_d = CMD;
      CMD:     if (ncs_rise) state_d = IDLE;
               else if (last_cmd) state_d = DATA;
      DATA:    if (ncs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      shadow_q  <= '0;
      cipo_q    <= 1'b0;
      regs_o    <= '0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
    end else begin
      state_q  <= state_d;
      wr_stb_o <= commit;
      if (commit) wr_addr_o <= addr_q;
      for (int k = 0; k < NUM_REGS; k++)
        if (commit && addr_q == ADDR_W'(k))
          regs_o[k*DATA_W +: DATA_W] <= data_q;

      if (state_q == IDLE) begin
        cipo_q <= 1'b0;
        if (ncs_fall) begin
          cnt_q <= '0;
          cmd_q <= '0;
        end
      end else if (sclk_rise && !ncs_rise) begin
        // Counter saturates one past FRAME so overlong frames stay flagged.
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
        if (state_q == CMD) cmd_q <= cmd_nx;
        if (state_q == DATA && cnt_q < CNT_FRAME)
          data_q <= {data_q[DATA_W-2:0], copi_q};
      end

      if (last_cmd && cmd_nx[ADDR_W] != RW_WRITE)
        shadow_q <= rd_val;
      if (rd_data && sclk_fall) begin
        cipo_q   <= shadow_q[DATA_W-1];
        shadow_q <= shadow_q << 1;
      end
    end
  end

  assign spi.cipo_oe_o = rd_data;
  assign spi.cipo_o    = rd_data & cipo_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench: default build plus a 16x16, 3-stage build on shared pins.
module tb_spi_reg_peripheral;

  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs = 1'b1;

  always #5 clk = ~clk;

  spi_reg_if if0 ();
  spi_reg_if if1 ();

  assign if0.sclk_i = sclk;
  assign if0.copi_i = copi;
  assign if0.ncs_i  = ncs;
  assign if1.sclk_i = sclk;
  assign if1.copi_i = copi;
  assign if1.ncs_i  = ncs;

  logic [39:0]  regs0;
  logic         stb0;
  logic [6:0]   wa0;
  logic [255:0] regs1;
  logic         stb1;
  logic [6:0]   wa1;

  spi_reg_peripheral dut0 (
    .clk(clk), .rst_n(rst_n), .spi(if0),
    .regs_o(regs0), .wr_stb_o(stb0), .wr_addr_o(wa0)
  );

  spi_reg_peripheral #(
    .NUM_REGS(16), .ADDR_W(7), .DATA_W(16), .SYNC_STAGES(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(if1),
    .regs_o(regs1), .wr_stb_o(stb1), .wr_addr_o(wa1)
  );

  typedef struct packed {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        q0[$];
  wr_t        q1[$];
  logic [7:0] rq[$];
  wr_t        e0, e1;
  logic [7:0]  m0[5];
  logic [15:0] m1[16];
  int n_run = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && stb0) begin
      check("stb0_expected", 256'(q0.size() > 0), 256'(1));
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("stb0_addr", 256'(wa0), 256'(e0.a));
        check("stb0_data", 256'(regs0[int'(e0.a)*8 +: 8]), 256'(e0.d[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && stb1) begin
      check("stb1_expected", 256'(q1.size() > 0), 256'(1));
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("stb1_addr", 256'(wa1), 256'(e1.a));
        check("stb1_data", 256'(regs1[int'(e1.a)*16 +: 16]), 256'(e1.d));
      end
    end
  end

  function automatic logic [39:0] flat0();
    logic [39:0] f;
    for (int k = 0; k < 5; k++) f[k*8 +: 8] = m0[k];
    return f;
  endfunction

  function automatic logic [255:0] flat1();
    logic [255:0] f;
    for (int k = 0; k < 16; k++) f[k*16 +: 16] = m1[k];
    return f;
  endfunction

  task automatic clear_models();
    for (int k = 0; k < 5; k++) m0[k] = '0;
    for (int k = 0; k < 16; k++) m1[k] = '0;
  endtask

  task automatic settle(string tag);
    repeat (10) @(negedge clk);
    check({tag, "_regs0"}, 256'(regs0), 256'(flat0()));
    check({tag, "_regs1"}, regs1, flat1());
    check({tag, "_q0_left"}, 256'(q0.size()), 256'(0));
    check({tag, "_q1_left"}, 256'(q1.size()), 256'(0));
    check({tag, "_oe_idle"}, 256'(if0.cipo_oe_o), 256'(0));
    check({tag, "_cipo_idle"}, 256'(if0.cipo_o), 256'(0));
  endtask

  task automatic spi_begin();
    @(negedge clk);
    ncs = 1'b0;
    #HALF;
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n,
                          output logic [31:0] rx, output logic [31:0] oe);
    rx = '0;
    oe = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      #HALF;
      rx = {rx[30:0], if0.cipo_o};
      oe = {oe[30:0], if0.cipo_oe_o};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    #HALF;
    ncs = 1'b1;
    copi = 1'b0;
  endtask

  task automatic wr0(input logic [6:0] a, input logic [7:0] d);
    logic [31:0] rx, oe;
    if (int'(a) < 5) begin
      m0[a] = d;
      q0.push_back('{a: a, d: {8'h00, d}});
    end
    spi_begin();
    spi_bits({16'h0, 1'b1, a, d}, 16, rx, oe);
    spi_end();
    check("wr0_oe", 256'(oe[15:0]), 256'(0));
  endtask

  task automatic wr1(input logic [6:0] a, input logic [15:0] d);
    logic [31:0] rx, oe;
    m1[a[3:0]] = d;
    q1.push_back('{a: a, d: d});
    spi_begin();
    spi_bits({8'h0, 1'b1, a, d}, 24, rx, oe);
    spi_end();
  endtask

  task automatic rd0(input logic [6:0] a);
    logic [31:0] rx, oe;
    logic [7:0]  exp;
    rq.push_back(int'(a) < 5 ? m0[a] : 8'h00);
    spi_begin();
    spi_bits({16'h0, 1'b0, a, 8'h00}, 16, rx, oe);
    spi_end();
    exp = rq.pop_front();
    check("rd0_data", 256'(rx[7:0]), 256'(exp));
    check("rd0_oe", 256'(oe[15:0]), 256'(16'h00FF));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, oe;
    logic [15:0] f16;
    clear_models();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_regs0", 256'(regs0), 256'(0));
    check("rst_regs1", regs1, 256'(0));
    check("rst_stb", 256'({stb0, stb1}), 256'(0));
    check("rst_waddr", 256'({wa0, wa1}), 256'(0));
    check("rst_oe", 256'(if0.cipo_oe_o), 256'(0));
    check("rst_cipo", 256'(if0.cipo_o), 256'(0));

    wr0(7'd0, 8'h80);
    settle("t1");
    check("t1_reg0", 256'(regs0[7:0]), 256'(8'h80));
    check("t1_waddr", 256'(wa0), 256'(0));

    wr0(7'd4, 8'hA5);
    settle("t2w");
    rd0(7'd4);
    settle("t2r");
    rd0(7'd0);
    settle("t2r0");

    wr0(7'h10, 8'h55);
    settle("t3w");
    rd0(7'h10);
    settle("t3r");

    f16 = {1'b1, 7'd1, 8'h77};
    spi_begin();
    spi_bits({16'h0, f16} >> 4, 12, rx, oe);
    spi_end();
    settle("t4short");
    spi_begin();
    spi_bits({15'h0, f16, 1'b1}, 17, rx, oe);
    spi_end();
    settle("t4long");

    @(negedge clk);
    spi_bits({16'h0, 1'b1, 7'd2, 8'h99}, 16, rx, oe);
    settle("t_ncs_high");

    f16 = {1'b1, 7'd1, 8'hC3};
    spi_begin();
    spi_bits({16'h0, f16} >> 7, 9, rx, oe);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_models();
    spi_bits({25'h0, f16[6:0]}, 7, rx, oe);
    spi_end();
    settle("t5rst");
    wr0(7'd1, 8'hC3);
    settle("t5next");

    wr0(7'd2, 8'h11);
    #(2 * HALF);
    wr0(7'd3, 8'h22);
    settle("t6b2b");

    wr1(7'd15, 16'hBEEF);
    #(2 * HALF);
    wr1(7'd0, 16'h1234);
    settle("t6wide");
    check("t6_reg15", 256'(regs1[255:240]), 256'(16'hBEEF));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
